// File: rtl/bingo_guess_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bingo_guess_ctrl_pkg
// Description : Shared types and constants for the bingo guess handler.
//               Holds the guess FSM encoding, the interboard message codes
//               and the game-FSM state codes used by the handler.
// Revision    : 1.0 - initial release
// ============================================================================
package bingo_guess_ctrl_pkg;

    // Per-turn guess FSM
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_MARK = 3'd2,
        S_SCAN = 3'd3,
        S_FIN  = 3'd4
    } guess_state_t;

    // Interboard message types
    localparam logic [2:0] c_msg_sel_num   = 3'd1;
    localparam logic [2:0] c_msg_state_win = 3'd2;

    // Game FSM states in which a guess is taken
    localparam logic [3:0] c_st_local  = 4'd4;
    localparam logic [3:0] c_st_remote = 4'd7;

endpackage
`default_nettype wire

// File: rtl/bingo_line_scanner.sv
`default_nettype none
// ============================================================================
// Module      : bingo_line_scanner
// Description : Combinational line check for an N x N board. Selects one of
//               the 2N+2 lines (rows 0..N-1, cols 0..N-1, main diagonal,
//               anti-diagonal) and reports whether every cell on it is marked.
// Ports       : i_circle    - marked cells, bit r*N+c is row r, column c
//               i_line_idx  - line to check
//               o_line_full - selected line completely marked
// Revision    : 1.0 - initial release
// ============================================================================
module bingo_line_scanner #(
    parameter int N      = 5,
    parameter int LIDX_W = $clog2(2*N+2)
) (
    input  logic [N*N-1:0]    i_circle,
    input  logic [LIDX_W-1:0] i_line_idx,
    output logic              o_line_full
);

    localparam int LINES = 2*N + 2;

    logic [LINES-1:0] w_full;
    logic [N-1:0]     w_main;
    logic [N-1:0]     w_anti;

    for (genvar r = 0; r < N; r++) begin : g_row
        assign w_full[r] = &i_circle[r*N +: N];
    end

    for (genvar c = 0; c < N; c++) begin : g_col
        logic [N-1:0] w_col;
        for (genvar i = 0; i < N; i++) begin : g_cell
            assign w_col[i] = i_circle[i*N + c];
        end
        assign w_full[N + c] = &w_col;
    end

    for (genvar i = 0; i < N; i++) begin : g_diag
        assign w_main[i] = i_circle[i*N + i];
        assign w_anti[i] = i_circle[i*N + (N-1-i)];
    end

    assign w_full[2*N]   = &w_main;
    assign w_full[2*N+1] = &w_anti;

    // Index is compared as an int so the guard stays correct when LINES is
    // an exact power of two.
    assign o_line_full = (int'(i_line_idx) < LINES) ? w_full[i_line_idx] : 1'b0;

endmodule
`default_nettype wire

// File: rtl/bingo_guess_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bingo_guess_ctrl
// Description : Per-turn guess handler for an N x N bingo board. Takes a local
//               guess (enter_pulse) or a remote SEL_NUM message, marks the
//               board, then scans every row, column and diagonal (one per
//               cycle) to report completed lines and a win flag.
//               Optional macro GUESS_TIMEOUT_EN adds a local-guess timeout
//               that auto-selects the lowest unmarked number.
// Ports       : clk, rst (async), interboard_rst (sync clear)
//               interboard_en/msg_type/number - remote guess message
//               cur_game_state, clear_guess, start_guess
//               cur_number, enter_pulse       - local guess
//               num_to_pos                    - number -> cell map
//               circle, guess_number, guess_local, guess_reject,
//               guess_timeout, line_count, bingo_win, guess_done
// Revision    : 1.0 - initial release
// ============================================================================
module bingo_guess_ctrl
    import bingo_guess_ctrl_pkg::*;
#(
    parameter int         N         = 5,
    parameter int         NUM_W     = $clog2(N*N+1),
    parameter int         POS_W     = $clog2(N*N),
    parameter int         LCNT_W    = $clog2(2*N+3),
    parameter int         WIN_LINES = N,
    parameter logic [3:0] ST_LOCAL  = c_st_local,
    parameter logic [3:0] ST_REMOTE = c_st_remote
`ifdef GUESS_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000_000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interboard_rst,
    input  logic                 interboard_en,
    input  logic [2:0]           interboard_msg_type,
    input  logic [NUM_W-1:0]     interboard_number,
    input  logic [3:0]           cur_game_state,
    input  logic                 clear_guess,
    input  logic                 start_guess,
    input  logic [NUM_W-1:0]     cur_number,
    input  logic                 enter_pulse,
    input  logic [POS_W*N*N-1:0] num_to_pos,
    output logic [N*N-1:0]       circle,
    output logic [NUM_W-1:0]     guess_number,
    output logic                 guess_local,
    output logic                 guess_reject,
    output logic                 guess_timeout,
    output logic [LCNT_W-1:0]    line_count,
    output logic                 bingo_win,
    output logic                 guess_done
);

    localparam int CELLS  = N*N;
    localparam int LINES  = 2*N + 2;
    localparam int LIDX_W = $clog2(LINES);
    localparam logic [LIDX_W-1:0] c_last_line = LIDX_W'(LINES-1);

    // Number k lives at num_to_pos[(k-1)*POS_W +: POS_W]; out-of-range
    // numbers map to cell 0 and are filtered by f_in_range.
    function automatic logic [POS_W-1:0] f_pos(input logic [NUM_W-1:0]       num,
                                               input logic [POS_W*CELLS-1:0] map);
        f_pos = '0;
        for (int k = 1; k <= CELLS; k++) begin
            if (num == NUM_W'(k)) f_pos = map[(k-1)*POS_W +: POS_W];
        end
    endfunction

    function automatic logic f_in_range(input logic [NUM_W-1:0] num);
        f_in_range = (num != '0) && (num <= NUM_W'(CELLS));
    endfunction

    guess_state_t       r_state;
    guess_state_t       w_state_next;
    logic [CELLS-1:0]   r_circle;
    logic [NUM_W-1:0]   r_guess_number;
    logic [POS_W-1:0]   r_guess_pos;
    logic               r_guess_local;
    logic               r_guess_reject;
    logic               r_guess_timeout;
    logic [LCNT_W-1:0]  r_line_count;
    logic [LCNT_W-1:0]  r_acc;
    logic               r_bingo_win;
    logic [LIDX_W-1:0]  r_line_idx;

    logic               w_in_wait;
    logic               w_local_sel;
    logic               w_remote_sel;
    logic [POS_W-1:0]   w_local_pos;
    logic               w_local_try;
    logic               w_local_ok;
    logic               w_remote_msg;
    logic               w_remote_try;
    logic               w_remote_ok;
    logic               w_remote_win;
    logic               w_reject;
    logic               w_timeout;
    logic               w_accept;
    logic [NUM_W-1:0]   w_sel_num;
    logic [POS_W-1:0]   w_sel_pos;
    logic               w_sel_local;
    logic               w_line_full;
    logic [LCNT_W-1:0]  w_acc_next;

    assign w_in_wait    = (r_state == S_WAIT);
    assign w_local_sel  = (cur_game_state == ST_LOCAL);
    assign w_remote_sel = (cur_game_state == ST_REMOTE);
    assign w_local_pos  = f_pos(cur_number, num_to_pos);

    // Only the source matching the game state is looked at; the other
    // source is ignored even when it fires in the same cycle.
    assign w_local_try  = w_in_wait & w_local_sel & enter_pulse;
    assign w_local_ok   = w_local_try & f_in_range(cur_number) & ~r_circle[w_local_pos];
    assign w_remote_msg = w_in_wait & w_remote_sel & interboard_en;
    assign w_remote_try = w_remote_msg & (interboard_msg_type == c_msg_sel_num);
    // A remote number already marked is still accepted: the board must
    // follow the opponent's turn even if it changes nothing.
    assign w_remote_ok  = w_remote_try & f_in_range(interboard_number);
    assign w_remote_win = w_remote_msg & (interboard_msg_type == c_msg_state_win);
    assign w_reject     = (w_local_try & ~w_local_ok) | (w_remote_try & ~w_remote_ok);

`ifdef GUESS_TIMEOUT_EN
    logic [31:0]      r_tmo_cnt;
    logic [NUM_W-1:0] w_auto_num;
    logic             w_auto_found;

    // Lowest unmarked number: scan downwards so the smallest hit wins.
    always_comb begin
        w_auto_num   = '0;
        w_auto_found = 1'b0;
        for (int k = CELLS; k >= 1; k--) begin
            if (!r_circle[f_pos(NUM_W'(k), num_to_pos)]) begin
                w_auto_num   = NUM_W'(k);
                w_auto_found = 1'b1;
            end
        end
    end

    // A valid enter in the expiry cycle takes precedence over the timeout.
    assign w_timeout = w_in_wait & w_local_sel & w_auto_found & ~w_local_ok &
                       (r_tmo_cnt == (TIMEOUT_CYC - 32'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (interboard_rst || clear_guess) begin
            r_tmo_cnt <= '0;
        end else if (w_in_wait && w_local_sel && !w_accept) begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_accept = w_local_ok | w_remote_ok | w_timeout;

    always_comb begin
        w_sel_num   = cur_number;
        w_sel_pos   = w_local_pos;
        w_sel_local = 1'b1;
        if (w_remote_ok) begin
            w_sel_num   = interboard_number;
            w_sel_pos   = f_pos(interboard_number, num_to_pos);
            w_sel_local = 1'b0;
        end
`ifdef GUESS_TIMEOUT_EN
        else if (w_timeout) begin
            w_sel_num   = w_auto_num;
            w_sel_pos   = f_pos(w_auto_num, num_to_pos);
            w_sel_local = 1'b1;
        end
`endif
    end

    bingo_line_scanner #(
        .N      (N),
        .LIDX_W (LIDX_W)
    ) u_line_scanner (
        .i_circle    (r_circle),
        .i_line_idx  (r_line_idx),
        .o_line_full (w_line_full)
    );

    assign w_acc_next = r_acc + LCNT_W'(w_line_full);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (interboard_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start_guess) w_state_next = S_WAIT;
            S_WAIT: begin
                if (w_accept)          w_state_next = S_MARK;
                else if (w_remote_win) w_state_next = S_IDLE;
            end
            S_MARK: w_state_next = S_SCAN;
            S_SCAN: if (r_line_idx == c_last_line) w_state_next = S_FIN;
            S_FIN:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (clear_guess) w_state_next = S_IDLE;
    end

    // ------------------------------------------------------------------
    // Board, latched guess and line accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_circle        <= '0;
            r_guess_number  <= '0;
            r_guess_pos     <= '0;
            r_guess_local   <= 1'b0;
            r_guess_reject  <= 1'b0;
            r_guess_timeout <= 1'b0;
            r_line_count    <= '0;
            r_acc           <= '0;
            r_bingo_win     <= 1'b0;
            r_line_idx      <= '0;
        end else if (interboard_rst) begin
            r_circle        <= '0;
            r_guess_number  <= '0;
            r_guess_pos     <= '0;
            r_guess_local   <= 1'b0;
            r_guess_reject  <= 1'b0;
            r_guess_timeout <= 1'b0;
            r_line_count    <= '0;
            r_acc           <= '0;
            r_bingo_win     <= 1'b0;
            r_line_idx      <= '0;
        end else if (clear_guess) begin
            r_circle        <= '0;
            r_guess_reject  <= 1'b0;
            r_guess_timeout <= 1'b0;
            r_line_count    <= '0;
            r_acc           <= '0;
            r_bingo_win     <= 1'b0;
            r_line_idx      <= '0;
        end else begin
            r_guess_reject  <= w_reject;
            r_guess_timeout <= w_timeout;
            if (w_accept) begin
                r_guess_number <= w_sel_num;
                r_guess_pos    <= w_sel_pos;
                r_guess_local  <= w_sel_local;
            end
            case (r_state)
                S_MARK: begin
                    r_circle[r_guess_pos] <= 1'b1;
                    r_line_idx            <= '0;
                    r_acc                 <= '0;
                end
                S_SCAN: begin
                    r_line_idx <= r_line_idx + LIDX_W'(1);
                    r_acc      <= w_acc_next;
                    if (r_line_idx == c_last_line) begin
                        r_line_count <= w_acc_next;
                        r_bingo_win  <= (w_acc_next >= LCNT_W'(WIN_LINES));
                    end
                end
                default: ;
            endcase
        end
    end

    assign circle        = r_circle;
    assign guess_number  = r_guess_number;
    assign guess_local   = r_guess_local;
    assign guess_reject  = r_guess_reject;
    assign guess_timeout = r_guess_timeout;
    assign line_count    = r_line_count;
    assign bingo_win     = r_bingo_win;
    assign guess_done    = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_bingo_guess_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bingo_guess_ctrl
// Description : Self-checking bench for bingo_guess_ctrl (N=5, WIN_LINES=5).
//               Accepted guesses push an expected record to a scoreboard that
//               is popped when guess_done fires. Covers GUESS_TIMEOUT_EN when
//               the macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bingo_guess_ctrl;
    import bingo_guess_ctrl_pkg::*;

    localparam int N      = 5;
    localparam int CELLS  = 25;
    localparam int NUM_W  = 5;
    localparam int POS_W  = 5;
    localparam int LCNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   interboard_rst;
    logic                   interboard_en;
    logic [2:0]             interboard_msg_type;
    logic [NUM_W-1:0]       interboard_number;
    logic [3:0]             cur_game_state;
    logic                   clear_guess;
    logic                   start_guess;
    logic [NUM_W-1:0]       cur_number;
    logic                   enter_pulse;
    logic [POS_W*CELLS-1:0] num_to_pos;
    logic [CELLS-1:0]       circle;
    logic [NUM_W-1:0]       guess_number;
    logic                   guess_local;
    logic                   guess_reject;
    logic                   guess_timeout;
    logic [LCNT_W-1:0]      line_count;
    logic                   bingo_win;
    logic                   guess_done;

    always #5 clk = ~clk;

`ifdef GUESS_TIMEOUT_EN
    bingo_guess_ctrl #(.N(N), .WIN_LINES(5), .TIMEOUT_CYC(32'd8)) dut (
`else
    bingo_guess_ctrl #(.N(N), .WIN_LINES(5)) dut (
`endif
        .clk                 (clk),
        .rst                 (rst),
        .interboard_rst      (interboard_rst),
        .interboard_en       (interboard_en),
        .interboard_msg_type (interboard_msg_type),
        .interboard_number   (interboard_number),
        .cur_game_state      (cur_game_state),
        .clear_guess         (clear_guess),
        .start_guess         (start_guess),
        .cur_number          (cur_number),
        .enter_pulse         (enter_pulse),
        .num_to_pos          (num_to_pos),
        .circle              (circle),
        .guess_number        (guess_number),
        .guess_local         (guess_local),
        .guess_reject        (guess_reject),
        .guess_timeout       (guess_timeout),
        .line_count          (line_count),
        .bingo_win           (bingo_win),
        .guess_done          (guess_done)
    );

    typedef struct {
        logic             remote;
        logic [NUM_W-1:0] num;
        logic             ok;
    } vec_t;

    typedef struct {
        logic [NUM_W-1:0]  num;
        logic              loc;
        logic [LCNT_W-1:0] lines;
        logic              win;
        logic [CELLS-1:0]  circ;
    } exp_t;

    exp_t             sb_q[$];
    int               n_cmp  = 0;
    int               n_err  = 0;
    int               n_done = 0;
    int               n_rej  = 0;
    int               n_tmo  = 0;
    int               map_a [1:CELLS];
    logic [CELLS-1:0] bm_circle;
    bit               in_wait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference line counter: rows, columns, both diagonals.
    function automatic int model_lines(input logic [CELLS-1:0] c);
        int  cnt = 0;
        bit  fr, fc, fm, fa;
        fm = 1; fa = 1;
        for (int a = 0; a < N; a++) begin
            fr = 1; fc = 1;
            for (int b = 0; b < N; b++) begin
                if (!c[a*N + b]) fr = 0;
                if (!c[b*N + a]) fc = 0;
            end
            cnt += int'(fr) + int'(fc);
            if (!c[a*N + a])         fm = 0;
            if (!c[a*N + (N-1-a)])   fa = 0;
        end
        return cnt + int'(fm) + int'(fa);
    endfunction

    task automatic set_map(input bit identity);
        for (int k = 1; k <= CELLS; k++) begin
            map_a[k] = identity ? (k - 1) : ((7 * k) % CELLS);
            num_to_pos[(k-1)*POS_W +: POS_W] = POS_W'(map_a[k]);
        end
    endtask

    task automatic push_expect(input logic [NUM_W-1:0] num, input logic loc);
        exp_t e;
        int   l;
        bm_circle[map_a[num]] = 1'b1;
        l       = model_lines(bm_circle);
        e.num   = num;
        e.loc   = loc;
        e.lines = LCNT_W'(l);
        e.win   = (l >= 5);
        e.circ  = bm_circle;
        sb_q.push_back(e);
    endtask

    // Scoreboard side: pulses are counted and completed turns compared.
    always @(negedge clk) begin : mon
        exp_t e;
        if (guess_reject)  n_rej++;
        if (guess_timeout) n_tmo++;
        if (guess_done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got guess_done=1 expected no pending guess");
            end else begin
                e = sb_q.pop_front();
                check("done_number", guess_number, e.num);
                check("done_local", guess_local, e.loc);
                check("done_line_count", line_count, e.lines);
                check("done_bingo_win", bingo_win, e.win);
                check("done_circle", circle, e.circ);
            end
        end
    end

    task automatic start_turn();
        @(negedge clk); start_guess = 1'b1;
        @(negedge clk); start_guess = 1'b0;
    endtask

    task automatic drive_local(input logic [NUM_W-1:0] num);
        @(negedge clk);
        cur_game_state = 4'd4; cur_number = num; enter_pulse = 1'b1;
        @(negedge clk);
        enter_pulse = 1'b0; cur_game_state = 4'd0;
    endtask

    task automatic drive_remote(input logic [2:0] mt, input logic [NUM_W-1:0] num);
        @(negedge clk);
        cur_game_state = 4'd7; interboard_msg_type = mt; interboard_number = num; interboard_en = 1'b1;
        @(negedge clk);
        interboard_en = 1'b0; cur_game_state = 4'd0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic guess(input vec_t v);
        int r0;
        if (!in_wait) begin start_turn(); in_wait = 1; end
        r0 = n_rej;
        if (v.ok) push_expect(v.num, !v.remote);
        if (v.remote) drive_remote(c_msg_sel_num, v.num);
        else          drive_local(v.num);
        if (v.ok) begin
            wait_drain("guess_done_wait");
            in_wait = 0;
            check("no_reject", n_rej, r0);
        end else begin
            @(negedge clk);
            check("reject_pulse", n_rej, r0 + 1);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   done_k, d0, r0;
        vec_t v;

        rst = 1'b1; interboard_rst = 1'b0; interboard_en = 1'b0; interboard_msg_type = '0;
        interboard_number = '0; cur_game_state = 4'd0; clear_guess = 1'b0; start_guess = 1'b0;
        cur_number = '0; enter_pulse = 1'b0; bm_circle = '0; in_wait = 0;
        set_map(1'b0);

        repeat (3) @(negedge clk);
        check("rst_circle", circle, 0);
        check("rst_guess_number", guess_number, 0);
        check("rst_guess_local", guess_local, 0);
        check("rst_guess_reject", guess_reject, 0);
        check("rst_guess_timeout", guess_timeout, 0);
        check("rst_line_count", line_count, 0);
        check("rst_bingo_win", bingo_win, 0);
        check("rst_guess_done", guess_done, 0);
        rst = 1'b0;

        // Latency of a local guess of 7 (scrambled map).
        start_turn();
        push_expect(5'd7, 1'b1);
        @(negedge clk);
        cur_game_state = 4'd4; cur_number = 5'd7; enter_pulse = 1'b1;
        done_k = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                enter_pulse = 1'b0; cur_game_state = 4'd0;
                check("lat_guess_number", guess_number, 7);
                check("lat_guess_local", guess_local, 1);
            end
            if (k == 2) check("lat_circle_bit", circle[map_a[7]], 1);
            if (guess_done) begin done_k = k; break; end
        end
        check("lat_done_cycle", done_k, 14);
        wait_drain("lat_drain");

        // Table of guesses: rejects keep the turn open, accepts finish it.
        tbl[0] = '{1'b0, 5'd0,  1'b0};
        tbl[1] = '{1'b0, 5'd26, 1'b0};
        tbl[2] = '{1'b0, 5'd7,  1'b0};
        tbl[3] = '{1'b0, 5'd1,  1'b1};
        tbl[4] = '{1'b1, 5'd13, 1'b1};
        tbl[5] = '{1'b1, 5'd0,  1'b0};
        tbl[6] = '{1'b1, 5'd7,  1'b1};
        tbl[7] = '{1'b0, 5'd2,  1'b1};
        tbl[8] = '{1'b1, 5'd30, 1'b0};
        tbl[9] = '{1'b0, 5'd25, 1'b1};
        for (int i = 0; i < 10; i++) guess(tbl[i]);

        // STATE_WIN ends the turn; a following SEL_NUM must be ignored.
        start_turn();
        d0 = n_done; r0 = n_rej;
        drive_remote(c_msg_state_win, 5'd0);
        drive_remote(c_msg_sel_num, 5'd11);
        repeat (20) @(negedge clk);
        check("win_no_done", n_done, d0);
        check("win_no_reject", n_rej, r0);

        // Enter and interboard message together in the local state.
        start_turn();
        push_expect(5'd9, 1'b1);
        @(negedge clk);
        cur_game_state = 4'd4; cur_number = 5'd9; enter_pulse = 1'b1;
        interboard_en = 1'b1; interboard_msg_type = c_msg_sel_num; interboard_number = 5'd10;
        @(negedge clk);
        enter_pulse = 1'b0; interboard_en = 1'b0; cur_game_state = 4'd0;
        wait_drain("simul_drain");

        // Interboard reset clears everything.
        @(negedge clk); interboard_rst = 1'b1;
        @(negedge clk); interboard_rst = 1'b0;
        check("ibrst_circle", circle, 0);
        check("ibrst_guess_number", guess_number, 0);
        check("ibrst_guess_local", guess_local, 0);
        bm_circle = '0;

        // clear_guess during SCAN aborts the turn.
        start_turn();
        drive_local(5'd20);
        repeat (3) @(negedge clk);
        @(negedge clk); clear_guess = 1'b1;
        @(negedge clk); clear_guess = 1'b0;
        check("clr_circle", circle, 0);
        check("clr_line_count", line_count, 0);
        check("clr_bingo_win", bingo_win, 0);
        d0 = n_done; r0 = n_rej;
        drive_local(5'd1);
        repeat (20) @(negedge clk);
        check("clr_no_done", n_done, d0);
        check("clr_idle_ignores_enter", n_rej, r0);
        bm_circle = '0;

        // Identity map: row 0 after 1..5, full board after 1..25.
        set_map(1'b1);
        for (int k = 1; k <= CELLS; k++) begin
            v.remote = (k % 2 == 0);
            v.num    = NUM_W'(k);
            v.ok     = 1'b1;
            guess(v);
            if (k == 5) check("row0_line_count", line_count, 1);
        end
        check("full_line_count", line_count, 12);
        check("full_bingo_win", bingo_win, 1);

`ifdef GUESS_TIMEOUT_EN
        @(negedge clk); interboard_rst = 1'b1;
        @(negedge clk); interboard_rst = 1'b0;
        bm_circle = '0;
        for (int k = 1; k <= 3; k++) begin
            v.remote = 1'b0; v.num = NUM_W'(k); v.ok = 1'b1;
            guess(v);
        end
        d0 = n_tmo;
        push_expect(5'd4, 1'b1);
        @(negedge clk); cur_game_state = 4'd4;
        start_turn();
        wait_drain("tmo_drain");
        cur_game_state = 4'd0;
        check("tmo_pulse", n_tmo, d0 + 1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
